controlador_ascensor: RTL and testbench

Sequencing controller for the four-floor elevator. It keeps the pending-request register for the 10 call buttons, with sticky set and clear-on-service. It drives the car motor and door using a SCAN policy: keep the current direction while demand lies ahead, otherwise reverse. It sits between the button inputs and the motor/door actuators, and replaces the stand-alone OR-only request latch.

---
 rtl/ascensor_pkg.sv | 45 ++++
 rtl/demanda_pisos.sv | 32 +++
 rtl/controlador_ascensor.sv | 172 +++++++++++++++++
 tb/tb_controlador_ascensor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ascensor_pkg.sv
// Shared definitions for the four-floor elevator controller.
// Holds the state encoding, button bit positions, per-floor request masks
// and the travel/door timer width.
package ascensor_pkg;

  localparam int TIMER_W = 8;
  localparam int N_BOT   = 10;
  localparam int N_PISOS = 4;

  // Controller states; the 2-bit encoding is kept explicit so the state
  // register stays compatible with older tools and waveform viewers.
  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    PUERTA   = 2'd3
  } estado_t;

  // Button bit positions inside the 10-bit request vector.
  localparam int B_P1_SUBIR  = 0;
  localparam int B_P2_BAJAR  = 1;
  localparam int B_P2_SUBIR  = 2;
  localparam int B_P3_BAJAR  = 3;
  localparam int B_P3_SUBIR  = 4;
  localparam int B_P4_BAJAR  = 5;
  localparam int B_CABINA_P1 = 6;
  localparam int B_CABINA_P2 = 7;
  localparam int B_CABINA_P3 = 8;
  localparam int B_CABINA_P4 = 9;

  // All button bits that belong to each floor: served together when the
  // door opens at that floor.
  localparam logic [N_BOT-1:0] FLOOR_MASK [N_PISOS] = '{
    (N_BOT'(1) << B_P1_SUBIR) | (N_BOT'(1) << B_CABINA_P1),
    (N_BOT'(1) << B_P2_BAJAR) | (N_BOT'(1) << B_P2_SUBIR) | (N_BOT'(1) << B_CABINA_P2),
    (N_BOT'(1) << B_P3_BAJAR) | (N_BOT'(1) << B_P3_SUBIR) | (N_BOT'(1) << B_CABINA_P3),
    (N_BOT'(1) << B_P4_BAJAR) | (N_BOT'(1) << B_CABINA_P4)
  };

  // Mask of the request bits of one floor.
  function automatic logic [N_BOT-1:0] mascara_piso(input logic [1:0] p);
    return FLOOR_MASK[p];
  endfunction

endpackage

// File: rtl/demanda_pisos.sv
// Per-floor demand and direction summary of the pending requests.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module demanda_pisos
  import ascensor_pkg::*;
(
  input  logic [N_BOT-1:0]   pendientes_i,
  input  logic [1:0]         piso_i,
  output logic [N_PISOS-1:0] dem_o,
  output logic               arriba_o,
  output logic               abajo_o
);

  // Fold the request bits of each floor into one demand flag.
  always_comb begin
    dem_o = '0;
    for (int k = 0; k < N_PISOS; k++) begin
      dem_o[k] = |(pendientes_i & FLOOR_MASK[k]);
    end
  end

  // Any demand strictly above / strictly below the reference floor.
  always_comb begin
    arriba_o = 1'b0;
    abajo_o  = 1'b0;
    for (int k = 0; k < N_PISOS; k++) begin
      if (k > int'(piso_i)) arriba_o = arriba_o | dem_o[k];
      if (k < int'(piso_i)) abajo_o  = abajo_o  | dem_o[k];
    end
  end

endmodule

// File: rtl/controlador_ascensor.sv
// SCAN sequencing controller: request latch, motor and door for 4 floors.
// Latency: press in cycle n lamps in n+1, state reacts in n+2.
// Backpressure: none; buttons are sticky, a 1-cycle pulse is enough.
module controlador_ascensor
  import ascensor_pkg::*;
#(
  parameter int unsigned T_PISO   = 8,
  parameter int unsigned T_PUERTA = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BOT-1:0] botones,
  output logic [N_BOT-1:0] pendientes,
  output logic [1:0]       piso,
  output logic             motor_subir,
  output logic             motor_bajar,
  output logic             puerta
);

  localparam logic [TIMER_W-1:0] CARGA_PISO   = TIMER_W'(T_PISO - 1);
  localparam logic [TIMER_W-1:0] CARGA_PUERTA = TIMER_W'(T_PUERTA - 1);

  estado_t             estado_q, estado_d;
  logic [1:0]          piso_q, piso_d;
  logic [N_BOT-1:0]    pend_q, pend_d;
  logic                dir_q, dir_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;

  // Demand seen from the current floor (REPOSO decisions).
  logic [N_PISOS-1:0]  dem_act;
  logic                arriba_act, abajo_act;

  // Demand seen from the floor the car reaches at the end of this leg.
  logic [1:0]          piso_lleg;
  logic [N_PISOS-1:0]  dem_lleg;
  logic                arriba_lleg, abajo_lleg;

  logic [N_BOT-1:0]    mask_servicio;
  logic                expira;

  demanda_pisos u_dem_actual (
    .pendientes_i (pend_q),
    .piso_i       (piso_q),
    .dem_o        (dem_act),
    .arriba_o     (arriba_act),
    .abajo_o      (abajo_act)
  );

  demanda_pisos u_dem_llegada (
    .pendientes_i (pend_q),
    .piso_i       (piso_lleg),
    .dem_o        (dem_lleg),
    .arriba_o     (arriba_lleg),
    .abajo_o      (abajo_lleg)
  );

  assign expira = (timer_q == '0);

  // Neighbour floor in the direction of travel; only meaningful while moving,
  // and the car never moves past the end floors because it only departs
  // towards existing demand.
  always_comb begin
    piso_lleg = piso_q;
    if (estado_q == SUBIENDO) piso_lleg = piso_q + 2'd1;
    if (estado_q == BAJANDO)  piso_lleg = piso_q - 2'd1;
  end

  // SCAN next-state logic with the travel/door timer.
  always_comb begin
    estado_d = estado_q;
    piso_d   = piso_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    unique case (estado_q)
      REPOSO: begin
        timer_d = '0;
        if (dem_act[piso_q]) begin
          estado_d = PUERTA;
          timer_d  = CARGA_PUERTA;
        end else if (arriba_act && (dir_q || !abajo_act)) begin
          estado_d = SUBIENDO;
          dir_d    = 1'b1;
          timer_d  = CARGA_PISO;
        end else if (abajo_act) begin
          estado_d = BAJANDO;
          dir_d    = 1'b0;
          timer_d  = CARGA_PISO;
        end
      end
      SUBIENDO: begin
        if (expira) begin
          piso_d = piso_lleg;
          if (dem_lleg[piso_lleg]) begin
            estado_d = PUERTA;
            timer_d  = CARGA_PUERTA;
          end else if (arriba_lleg) begin
            // Keep driving through the floor without a gap on the motor.
            timer_d  = CARGA_PISO;
          end else begin
            estado_d = REPOSO;
            timer_d  = '0;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      BAJANDO: begin
        if (expira) begin
          piso_d = piso_lleg;
          if (dem_lleg[piso_lleg]) begin
            estado_d = PUERTA;
            timer_d  = CARGA_PUERTA;
          end else if (abajo_lleg) begin
            timer_d  = CARGA_PISO;
          end else begin
            estado_d = REPOSO;
            timer_d  = '0;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      PUERTA: begin
        // Fixed dwell: presses at this floor are swallowed by the mask and
        // never reload the timer.
        if (expira) begin
          estado_d = REPOSO;
          timer_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        estado_d = REPOSO;
        timer_d  = '0;
      end
    endcase
  end

  // Sticky request latch; serving a floor clears it and beats a same-cycle press.
  always_comb begin
    mask_servicio = '0;
    if (estado_d == PUERTA) mask_servicio = mascara_piso(piso_d);
    pend_d = (pend_q | botones) & ~mask_servicio;
  end

  // State, position, direction, timer and request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= REPOSO;
      piso_q   <= 2'd0;
      pend_q   <= '0;
      dir_q    <= 1'b1;
      timer_q  <= '0;
    end else begin
      estado_q <= estado_d;
      piso_q   <= piso_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
    end
  end

  // Actuators decode from the state register alone, so they are mutually
  // exclusive and a reversal always shows at least one idle cycle.
  assign motor_subir = (estado_q == SUBIENDO);
  assign motor_bajar = (estado_q == BAJANDO);
  assign puerta      = (estado_q == PUERTA);
  assign pendientes  = pend_q;
  assign piso        = piso_q;

endmodule

// File: tb/tb_controlador_ascensor.sv
// Directed bench for controlador_ascensor with T_PISO=8, T_PUERTA=4.
// Cycle 0 is the cycle a button pulse is driven; checks sample #1 after posedge.
module tb_controlador_ascensor;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] botones;
  logic [9:0] pendientes;
  logic [1:0] piso;
  logic       motor_subir;
  logic       motor_bajar;
  logic       puerta;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  controlador_ascensor #(.T_PISO(8), .T_PUERTA(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .botones     (botones),
    .pendientes  (pendientes),
    .piso        (piso),
    .motor_subir (motor_subir),
    .motor_bajar (motor_bajar),
    .puerta      (puerta)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic hasta(input int n);
    while (cyc < n) tick();
  endtask

  // Drive a 1-cycle pulse in cycle 0; returns in cycle 1.
  task automatic pulso(input logic [9:0] m);
    botones = m;
    cyc = 0;
    tick();
    botones = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Actuators packed as {subir, bajar, puerta}.
  function automatic logic [31:0] act();
    return {29'd0, motor_subir, motor_bajar, puerta};
  endfunction

  initial begin
    reset   = 1'b1;
    botones = '0;
    tick(); tick(); tick();
    chk("reset_act",  act(),      32'd0);
    chk("reset_piso", piso,       32'd0);
    chk("reset_pend", pendientes, 32'd0);
    reset = 1'b0;

    // Idle after reset: no motion for 50 cycles.
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_act", act(), 32'd0);
    end
    chk("idle_pend", pendientes, 32'd0);

    // Cabin p1 at floor p1: door opens in place.
    pulso(10'b00_0100_0000);
    chk("a_pend1",   pendientes, 32'h040);
    chk("a_act1",    act(),      32'd0);
    tick();
    chk("a_door2",   act(),      32'd1);
    chk("a_clr2",    pendientes, 32'd0);
    hasta(5);
    chk("a_door5",   act(),      32'd1);
    tick();
    chk("a_idle6",   act(),      32'd0);

    // Cabin p4 from p1: three floors of travel then door.
    pulso(10'b10_0000_0000);
    chk("b_act1",    act(),      32'd0);
    tick();
    chk("b_up2",     act(),      32'd4);
    hasta(9);
    chk("b_piso9",   piso,       32'd0);
    tick();
    chk("b_piso10",  piso,       32'd1);
    chk("b_up10",    act(),      32'd4);
    hasta(17);
    chk("b_piso17",  piso,       32'd1);
    tick();
    chk("b_piso18",  piso,       32'd2);
    hasta(25);
    chk("b_up25",    act(),      32'd4);
    chk("b_pend25",  pendientes, 32'h200);
    tick();
    chk("b_piso26",  piso,       32'd3);
    chk("b_door26",  act(),      32'd1);
    chk("b_pend26",  pendientes, 32'd0);
    hasta(29);
    chk("b_door29",  act(),      32'd1);
    tick();
    chk("b_idle30",  act(),      32'd0);

    // Back down to p1 with cabin p1.
    pulso(10'b00_0100_0000);
    tick();
    chk("r_down2",   act(),      32'd2);
    hasta(10);
    chk("r_piso10",  piso,       32'd2);
    hasta(25);
    chk("r_down25",  act(),      32'd2);
    tick();
    chk("r_piso26",  piso,       32'd0);
    chk("r_door26",  act(),      32'd1);
    hasta(30);
    chk("r_idle30",  act(),      32'd0);

    // Hall p2-up and cabin p4: intermediate stop at p2, then on to p4.
    pulso(10'b10_0000_0100);
    chk("c_pend1",   pendientes, 32'h204);
    hasta(9);
    chk("c_up9",     act(),      32'd4);
    tick();
    chk("c_piso10",  piso,       32'd1);
    chk("c_door10",  act(),      32'd1);
    chk("c_pend10",  pendientes, 32'h200);
    // Press p2-up again while the door is open: swallowed, no extension.
    tick();
    botones = 10'b00_0000_0100;
    tick();
    botones = '0;
    chk("c_pend12",  pendientes, 32'h200);
    hasta(13);
    chk("c_door13",  act(),      32'd1);
    tick();
    chk("c_idle14",  act(),      32'd0);
    tick();
    chk("c_up15",    act(),      32'd4);
    hasta(30);
    chk("c_piso30",  piso,       32'd2);
    tick();
    chk("c_piso31",  piso,       32'd3);
    chk("c_door31",  act(),      32'd1);
    hasta(34);
    chk("c_door34",  act(),      32'd1);
    tick();
    chk("c_idle35",  act(),      32'd0);
    chk("c_pend35",  pendientes, 32'd0);

    // Reposition: down to p1, then up to p2 so dir ends as up.
    pulso(10'b00_0100_0000);
    hasta(30);
    chk("p_piso0",   piso,       32'd0);
    pulso(10'b00_1000_0000);
    hasta(14);
    chk("p_piso1",   piso,       32'd1);
    chk("p_idle14",  act(),      32'd0);

    // At p2 going up with cabin p1 and p4 pending: up first, then reverse.
    pulso(10'b10_0100_0000);
    tick();
    chk("d_up2",     act(),      32'd4);
    hasta(10);
    chk("d_piso10",  piso,       32'd2);
    hasta(18);
    chk("d_piso18",  piso,       32'd3);
    chk("d_door18",  act(),      32'd1);
    chk("d_pend18",  pendientes, 32'h040);
    hasta(21);
    chk("d_door21",  act(),      32'd1);
    tick();
    chk("d_idle22",  act(),      32'd0);
    tick();
    chk("d_down23",  act(),      32'd2);
    hasta(31);
    chk("d_piso31",  piso,       32'd2);
    hasta(39);
    chk("d_piso39",  piso,       32'd1);
    hasta(47);
    chk("d_piso47",  piso,       32'd0);
    chk("d_door47",  act(),      32'd1);
    chk("d_pend47",  pendientes, 32'd0);
    hasta(51);
    chk("d_idle51",  act(),      32'd0);

    // Reset in cycle 5 of upward travel.
    pulso(10'b10_0000_0000);
    hasta(5);
    chk("e_up5",     act(),      32'd4);
    reset = 1'b1;
    tick();
    chk("e_act6",    act(),      32'd0);
    chk("e_piso6",   piso,       32'd0);
    chk("e_pend6",   pendientes, 32'd0);
    reset = 1'b0;

    // Reset after the car has left p1: position and requests are lost.
    pulso(10'b10_0000_0000);
    hasta(12);
    chk("f_piso12",  piso,       32'd1);
    reset = 1'b1;
    tick();
    chk("f_act",     act(),      32'd0);
    chk("f_piso",    piso,       32'd0);
    chk("f_pend",    pendientes, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("f_idle",  act(),      32'd0);
    end

    // Reset with the door open.
    pulso(10'b00_0100_0000);
    hasta(3);
    chk("g_door3",   act(),      32'd1);
    reset = 1'b1;
    tick();
    chk("g_act",     act(),      32'd0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
